// File: rtl/mm_arbiter.sv
// mm_arbiter: two-client line-port arbiter sharing one mainmemory port between two L1 caches
// Ports: clk, reset (sync, active-high); per client N: cN_a/cN_read/cN_write/cN_wd requests,
// cN_ready (buffer empty), cN_rd/cN_rd_valid fill return; memory side: mm_a/mm_read/mm_write/mm_wd
// commands, mm_rd/mm_rd_valid fill data, mm_ready command acceptance.
// Build option: MM_ARB_FIXED_PRIO_EN selects fixed priority (client 0 wins ties) instead of round-robin.
module mm_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] c0_a,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [LINE_W-1:0] c0_wd,
  output logic              c0_ready,
  output logic [LINE_W-1:0] c0_rd,
  output logic              c0_rd_valid,
  input  logic [ADDR_W-1:0] c1_a,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [LINE_W-1:0] c1_wd,
  output logic              c1_ready,
  output logic [LINE_W-1:0] c1_rd,
  output logic              c1_rd_valid,
  output logic [ADDR_W-1:0] mm_a,
  output logic              mm_read,
  output logic              mm_write,
  output logic [LINE_W-1:0] mm_wd,
  input  logic [LINE_W-1:0] mm_rd,
  input  logic              mm_rd_valid,
  input  logic              mm_ready
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_GAP} state_t;
  state_t state, state_n;
  logic [1:0] buf_v, buf_w, req_r, req_w, cap, clr, rd_v, rd_valid_n;
  logic [ADDR_W-1:0] buf_a [2];
  logic [ADDR_W-1:0] req_a [2];
  logic [LINE_W-1:0] buf_d [2];
  logic [LINE_W-1:0] req_d [2];
  logic [LINE_W-1:0] rd_q [2];
  logic [LINE_W-1:0] rd_n [2];
  logic owner, owner_n, win, issue, mm_read_n, mm_write_n;
  logic [ADDR_W-1:0] mm_a_n;
  logic [LINE_W-1:0] mm_wd_n;
  assign req_r = {c1_read, c0_read};
  assign req_w = {c1_write, c0_write};
  assign req_a = '{c0_a, c1_a};
  assign req_d = '{c0_wd, c1_wd};
  assign c0_ready = !buf_v[0] && !reset;
  assign c1_ready = !buf_v[1] && !reset;
  assign c0_rd = rd_q[0];
  assign c1_rd = rd_q[1];
  assign c0_rd_valid = rd_v[0];
  assign c1_rd_valid = rd_v[1];
  // an empty buffer is exactly a ready client, so capture never collides with issue or fill
  assign cap = ~buf_v & (req_r | req_w);
  assign issue = (state == IDLE) && (|buf_v) && mm_ready;
`ifdef MM_ARB_FIXED_PRIO_EN
  assign win = !buf_v[0];
`else
  logic last_grant;
  always_ff @(posedge clk) begin
    if (reset) last_grant <= 1'b1;
    else if (issue) last_grant <= win;
  end
  // a lone requester wins; on a tie the client not granted last time wins
  assign win = &buf_v ? !last_grant : buf_v[1];
`endif
  always_comb begin
    state_n = state;
    owner_n = owner;
    mm_read_n = 1'b0;
    mm_write_n = 1'b0;
    mm_a_n = mm_a;
    mm_wd_n = mm_wd;
    clr = '0;
    rd_valid_n = '0;
    rd_n = rd_q;
    if (issue) begin
      owner_n = win;
      mm_a_n = {buf_a[win][ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      mm_wd_n = buf_d[win];
      mm_read_n = !buf_w[win];
      mm_write_n = buf_w[win];
      // writes are posted: the buffer frees at issue; reads hold it until the fill
      clr[win] = buf_w[win];
      state_n = buf_w[win] ? WR_GAP : RD_WAIT;
    end else if (state == RD_WAIT && mm_rd_valid) begin
      rd_n[owner] = mm_rd;
      rd_valid_n[owner] = 1'b1;
      clr[owner] = 1'b1;
      state_n = IDLE;
    end else if (state == WR_GAP) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (cap[n]) begin
        buf_a[n] <= req_a[n];
        buf_d[n] <= req_d[n];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      buf_v <= '0;
      buf_w <= '0;
      owner <= 1'b0;
      mm_read <= 1'b0;
      mm_write <= 1'b0;
      mm_a <= '0;
      mm_wd <= '0;
      rd_q <= '{default: '0};
      rd_v <= '0;
    end else begin
      state <= state_n;
      buf_v <= (buf_v & ~clr) | cap;
      // a simultaneous read and write captures the read only
      buf_w <= (buf_w & ~cap) | (cap & req_w & ~req_r);
      owner <= owner_n;
      mm_read <= mm_read_n;
      mm_write <= mm_write_n;
      mm_a <= mm_a_n;
      mm_wd <= mm_wd_n;
      rd_q <= rd_n;
      rd_v <= rd_valid_n;
    end
  end
endmodule

// File: tb/tb_mm_arbiter.sv
// tb_mm_arbiter: table-driven and scoreboarded bench for mm_arbiter
module tb_mm_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] c0_a = '0, c1_a = '0, mm_a;
  logic c0_read = 0, c0_write = 0, c1_read = 0, c1_write = 0;
  logic [LW-1:0] c0_wd = '0, c1_wd = '0, c0_rd, c1_rd, mm_wd, mm_rd = '0;
  logic c0_ready, c1_ready, c0_rd_valid, c1_rd_valid, mm_read, mm_write;
  logic mm_rd_valid = 0, mm_ready = 1;
  always #5 clk = ~clk;
  mm_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_a(c0_a), .c0_read(c0_read), .c0_write(c0_write), .c0_wd(c0_wd),
    .c0_ready(c0_ready), .c0_rd(c0_rd), .c0_rd_valid(c0_rd_valid),
    .c1_a(c1_a), .c1_read(c1_read), .c1_write(c1_write), .c1_wd(c1_wd),
    .c1_ready(c1_ready), .c1_rd(c1_rd), .c1_rd_valid(c1_rd_valid),
    .mm_a(mm_a), .mm_read(mm_read), .mm_write(mm_write), .mm_wd(mm_wd),
    .mm_rd(mm_rd), .mm_rd_valid(mm_rd_valid), .mm_ready(mm_ready)
  );
  typedef struct {
    logic r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [LW-1:0] d0, d1;
    logic first_rr, first_fp;
  } vec_t;
  typedef struct {
    logic wr;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } cmd_t;
  vec_t vecs [9];
  cmd_t cmd_q [$];
  logic [LW-1:0] fill_q0 [$];
  logic [LW-1:0] fill_q1 [$];
  int checks = 0, errors = 0, cyc = 0, cmd_cyc = -100, fill_cyc = -100, mem_cnt = 0;
  logic outstanding = 0, mem_en = 1;
  logic [AW-1:0] mem_addr = '0;
  function automatic logic [LW-1:0] pat(logic [AW-1:0] a);
    return {8{a ^ 32'h5a5a_0000}};
  endfunction
  task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic monitor();
    cmd_t e;
    if (mm_read || mm_write) begin
      cmd_cyc = cyc;
      check("one_outstanding", LW'(outstanding), '0);
      if (cmd_q.size() == 0) check("mm_cmd_unexpected", LW'(mm_a), '1);
      else begin
        e = cmd_q.pop_front();
        check("mm_cmd_kind", LW'({mm_read, mm_write}), LW'({!e.wr, e.wr}));
        check("mm_a", LW'(mm_a), LW'(e.a));
        if (e.wr) check("mm_wd", mm_wd, e.d);
      end
      if (mm_read) outstanding = 1;
    end
    if (c0_rd_valid) begin
      fill_cyc = cyc;
      outstanding = 0;
      if (fill_q0.size() == 0) check("c0_rd_valid_unexpected", 1, 0);
      else check("c0_rd", c0_rd, fill_q0.pop_front());
    end
    if (c1_rd_valid) begin
      fill_cyc = cyc;
      outstanding = 0;
      if (fill_q1.size() == 0) check("c1_rd_valid_unexpected", 1, 0);
      else check("c1_rd", c1_rd, fill_q1.pop_front());
    end
  endtask
  task automatic mem_model();
    if (mem_en) begin
      mm_rd_valid = 0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mm_rd_valid = 1;
          mm_rd = pat(mem_addr);
        end
      end
      if (mm_read) begin
        mem_cnt = 2;
        mem_addr = mm_a;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    mem_model();
  endtask
  task automatic expect_cmd(int n, logic r, logic w, logic [AW-1:0] a, logic [LW-1:0] d);
    logic [AW-1:0] am;
    am = a & ~32'h1f;
    if (r || w) cmd_q.push_back('{wr: w && !r, a: am, d: d});
    if (r && n == 0) fill_q0.push_back(pat(am));
    if (r && n == 1) fill_q1.push_back(pat(am));
  endtask
  task automatic wait_idle();
    logic done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (c0_ready && c1_ready && !outstanding && cmd_q.size() == 0 && fill_q0.size() == 0 && fill_q1.size() == 0) done = 1;
      else tick();
    end
    check("idle_timeout", LW'(done), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    logic first;
    vecs[0] = '{1, 0, 0, 0, 32'h0000_1234, 0, '0, '0, 0, 0};
    vecs[1] = '{0, 0, 0, 1, 0, 32'h40, '0, {64{4'h5}}, 1, 1};
    vecs[2] = '{1, 0, 1, 0, 32'h100, 32'h200, '0, '0, 0, 0};
    vecs[3] = '{1, 0, 1, 0, 32'h300, 32'h400, '0, '0, 0, 0};
    vecs[4] = '{0, 1, 1, 0, 32'h520, 32'h600, {32{8'hA5}}, '0, 0, 0};
    vecs[5] = '{0, 0, 1, 0, 0, 32'h71f, '0, '0, 1, 1};
    vecs[6] = '{1, 0, 0, 1, 32'h800, 32'h900, '0, {16{16'hbeef}}, 0, 0};
    vecs[7] = '{1, 1, 0, 0, 32'h1000, 0, {64{4'hF}}, '0, 0, 0};
    vecs[8] = '{1, 0, 1, 0, 32'hA0, 32'hC0, '0, '0, 1, 0};
    tick();
    tick();
    check("rst_ready", LW'({c1_ready, c0_ready}), 0);
    check("rst_rd_valid", LW'({c1_rd_valid, c0_rd_valid}), 0);
    check("rst_mm_cmd", LW'({mm_read, mm_write}), 0);
    check("rst_mm_a", LW'(mm_a), 0);
    check("rst_mm_wd", mm_wd, 0);
    check("rst_rd", c0_rd | c1_rd, 0);
    reset = 0;
    #1;
    check("ready_after_rst", LW'({c1_ready, c0_ready}), 2'b11);
    for (int i = 0; i < 9; i++) begin
`ifdef MM_ARB_FIXED_PRIO_EN
      first = vecs[i].first_fp;
`else
      first = vecs[i].first_rr;
`endif
      if (first) begin
        expect_cmd(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
        expect_cmd(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
      end else begin
        expect_cmd(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0);
        expect_cmd(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      end
      {c0_read, c0_write, c1_read, c1_write} = {vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1};
      {c0_a, c1_a, c0_wd, c1_wd} = {vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1};
      tick();
      {c0_read, c0_write, c1_read, c1_write} = '0;
      wait_idle();
    end
    // single read latency
    t = cyc;
    expect_cmd(0, 1, 0, 32'h0000_1234, '0);
    c0_a = 32'h0000_1234;
    c0_read = 1;
    tick();
    c0_read = 0;
    check("rd_ready_t1", LW'(c0_ready), 0);
    tick();
    check("rd_cmd_t2", LW'(cmd_cyc), LW'(t + 2));
    wait_idle();
    check("rd_fill_t5", LW'(fill_cyc), LW'(t + 5));
    // posted write followed by a read queued behind the write gap
    t = cyc;
    expect_cmd(1, 0, 1, 32'h40, {64{4'h5}});
    c1_a = 32'h40;
    c1_wd = {64{4'h5}};
    c1_write = 1;
    tick();
    c1_write = 0;
    expect_cmd(0, 1, 0, 32'h80, '0);
    c0_a = 32'h80;
    c0_read = 1;
    tick();
    c0_read = 0;
    check("wr_cmd_t2", LW'(cmd_cyc), LW'(t + 2));
    check("wr_ready_t2", LW'(c1_ready), 1);
    tick();
    check("wr_gap_t3", LW'(cmd_cyc), LW'(t + 2));
    tick();
    check("wr_next_t4", LW'(cmd_cyc), LW'(t + 4));
    wait_idle();
    // backpressure
    mm_ready = 0;
    t = cyc;
    expect_cmd(0, 1, 0, 32'h2000, '0);
    c0_a = 32'h2000;
    c0_read = 1;
    tick();
    c0_read = 0;
    for (int i = 0; i < 10; i++) begin
      check("bp_ready", LW'(c0_ready), 0);
      check("bp_no_cmd", LW'(cmd_cyc < t), 1);
      tick();
    end
    t = cyc;
    mm_ready = 1;
    tick();
    check("bp_issue", LW'(cmd_cyc), LW'(t + 1));
    wait_idle();
    // stray fill data while idle
    mem_en = 0;
    mm_rd = '1;
    mm_rd_valid = 1;
    tick();
    mm_rd_valid = 0;
    check("stray_rd_valid", LW'({c1_rd_valid, c0_rd_valid}), 0);
    mem_en = 1;
    // reset while a read is outstanding
    mem_en = 0;
    expect_cmd(0, 1, 0, 32'h3000, '0);
    c0_a = 32'h3000;
    c0_read = 1;
    tick();
    c0_read = 0;
    tick();
    check("rst_rd_issued", LW'(outstanding), 1);
    reset = 1;
    tick();
    check("rst_mid_cmd", LW'({mm_read, mm_write}), 0);
    reset = 0;
    #1;
    check("rst_mid_ready", LW'({c1_ready, c0_ready}), 2'b11);
    fill_q0.delete();
    outstanding = 0;
    mm_rd = pat(32'h3000);
    mm_rd_valid = 1;
    tick();
    mm_rd_valid = 0;
    check("rst_abandon_fill", LW'({c1_rd_valid, c0_rd_valid}), 0);
    tick();
    check("rst_abandon_fill2", LW'({c1_rd_valid, c0_rd_valid}), 0);
    mem_en = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
